// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between decode/execute and the iterative multiply/divide unit.
// master drives requests; slave is the unit itself.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             flush;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, input1, input2, flush,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, input1, input2, flush,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// signed ops run on magnitudes with the sign fixed up when HI/LO are written.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StZero} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  // Operand magnitudes; the magnitude of the most negative value still fits as unsigned.
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  assign s1   = bus.op[0] & bus.input1[WIDTH-1];
  assign s2   = bus.op[0] & bus.input2[WIDTH-1];
  assign mag1 = s1 ? -bus.input1 : bus.input1;
  assign mag2 = s2 ? -bus.input2 : bus.input2;

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               unused_trial;

  assign mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? a_q : '0);
  assign div_sh       = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial    = {1'b0, div_sh} - {1'b0, a_q};
  assign div_ok       = ~div_trial[WIDTH+1];
  assign unused_trial = div_trial[WIDTH];
  assign step = is_div_q ? {(div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                            acc_q[WIDTH-2:0], div_ok}
                         : {mul_sum, acc_q[WIDTH-1:1]};
  assign prod = neg_lo_q ? -step : step;
  assign quo  = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem  = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          neg_lo_d = s1 ^ s2;
          neg_hi_d = s1;
          dbz_d    = 1'b0;
          cnt_d    = '0;
          if (!bus.op[1]) begin
            a_d     = {1'b0, mag1};
            acc_d   = {{WIDTH{1'b0}}, mag2};
            state_d = StRun;
          end else if (bus.input2 == '0) begin
            // Raw dividend is kept so HI can report it unchanged.
            acc_d   = {{WIDTH{1'b0}}, bus.input1};
            state_d = StZero;
          end else begin
            a_d     = {1'b0, mag2};
            acc_d   = {{WIDTH{1'b0}}, mag1};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StZero: begin
        state_d = StIdle;
        if (!bus.flush) begin
          hi_d   = acc_q[WIDTH-1:0];
          lo_d   = '1;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of hand-computed results plus sequences for
// flush, ignored start, back-to-back start, mid-operation reset and start+flush.
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Called just after a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op     = op;
    bus.input1 = a;
    bus.input2 = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.input1 = $urandom;
    bus.input2 = $urandom;
  endtask

  task automatic wait_done(output bit seen, output int busy_cyc);
    seen     = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    int bc;
    int hits;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32};
    vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32};
    vecs[4]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5]  = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 32};
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32};
    vecs[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32};
    vecs[10] = '{2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 32};
    vecs[11] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32};
    vecs[12] = '{2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1};
    vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 32};
    vecs[14] = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};

    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.input1 = '0; bus.input2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset dbz", {63'd0, bus.divByZero}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(seen, bc);
      check($sformatf("v%0d done", i), {63'd0, seen}, 64'd1);
      check($sformatf("v%0d busy cycles", i), 64'(bc), 64'(vecs[i].busy));
      check($sformatf("v%0d hi", i), {32'd0, bus.hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d lo", i), {32'd0, bus.lo}, {32'd0, vecs[i].lo});
      check($sformatf("v%0d dbz", i), {63'd0, bus.divByZero}, {63'd0, vecs[i].dbz});
      @(negedge clk);
      check($sformatf("v%0d done pulse", i), {63'd0, bus.done}, 64'd0);
      check($sformatf("v%0d hold", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
    end

    // Start during busy is ignored: original operands complete, nothing queued.
    issue(2'b00, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    bus.op = 2'b00; bus.input1 = 32'd9; bus.input2 = 32'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(seen, bc);
    check("ign done", {63'd0, seen}, 64'd1);
    check("ign busy cycles", 64'(bc), 64'd27);
    check("ign result", {bus.hi, bus.lo}, 64'd25);
    @(negedge clk);
    check("ign no requeue", {63'd0, bus.busy}, 64'd0);

    // Flush at cycle 10 with an ignored start at cycle 5.
    issue(2'b10, 32'd100, 32'd7);
    wait_done(seen, bc);
    @(negedge clk);
    issue(2'b00, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    bus.input1 = 32'd3; bus.input2 = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", {63'd0, bus.busy}, 64'd0);
    check("flush done", {63'd0, bus.done}, 64'd0);
    check("flush hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) hits++;
    end
    check("flush quiet", 64'(hits), 64'd0);

    // Start accepted in the done cycle.
    issue(2'b00, 32'd4, 32'd4);
    wait_done(seen, bc);
    check("b2b first", {bus.hi, bus.lo}, 64'd16);
    bus.op = 2'b00; bus.input1 = 32'd2; bus.input2 = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b busy", {63'd0, bus.busy}, 64'd1);
    check("b2b hold", {bus.hi, bus.lo}, 64'd16);
    wait_done(seen, bc);
    check("b2b done", {63'd0, seen}, 64'd1);
    check("b2b busy cycles", 64'(bc), 64'd32);
    check("b2b result", {bus.hi, bus.lo}, 64'd6);
    @(negedge clk);

    // Reset at cycle 16 of a divide.
    issue(2'b10, 32'd100, 32'd7);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst done", {63'd0, bus.done}, 64'd0);
    check("rst dbz", {63'd0, bus.divByZero}, 64'd0);
    check("rst hilo", {bus.hi, bus.lo}, 64'd0);

    // start together with flush is not accepted.
    bus.op = 2'b00; bus.input1 = 32'd7; bus.input2 = 32'd7;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("sf busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("sf no done", {bus.hi, bus.lo}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
